// File: rtl/video_timing_pkg.sv
// Shared types, standard mode timings and helpers for the HDMI video timing controller.
package video_timing_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // 1280x720@60
  localparam int M720_H_ACTIVE = 1280;
  localparam int M720_H_FP     = 110;
  localparam int M720_H_SYNC   = 40;
  localparam int M720_H_BP     = 220;
  localparam int M720_V_ACTIVE = 720;
  localparam int M720_V_FP     = 5;
  localparam int M720_V_SYNC   = 5;
  localparam int M720_V_BP     = 20;

  // 640x480@60
  localparam int M480_H_ACTIVE = 640;
  localparam int M480_H_FP     = 16;
  localparam int M480_H_SYNC   = 96;
  localparam int M480_H_BP     = 48;
  localparam int M480_V_ACTIVE = 480;
  localparam int M480_V_FP     = 10;
  localparam int M480_V_SYNC   = 2;
  localparam int M480_V_BP     = 33;

  // {display_enable, vsync, hsync} with both syncs inactive and no picture
  function automatic logic [2:0] hve_idle(input logic hs_pol, input logic vs_pol);
    return {1'b0, ~vs_pol, ~hs_pol};
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with asynchronous reset to a programmable idle value.
module video_delay_line #(
  parameter int               WIDTH = 3,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             hdmi_clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      sr <= {DEPTH{INIT}};
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/video_timing.sv
// Video timing controller: h/v counters, frame-aligned start/stop, fetch requests LEAD cycles
// ahead of the {display_enable, vsync, hsync} triple sent to the hdmi block.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = M720_H_ACTIVE,
  parameter int   H_FP     = M720_H_FP,
  parameter int   H_SYNC   = M720_H_SYNC,
  parameter int   H_BP     = M720_H_BP,
  parameter int   V_ACTIVE = M720_V_ACTIVE,
  parameter int   V_FP     = M720_V_FP,
  parameter int   V_SYNC   = M720_V_SYNC,
  parameter int   V_BP     = M720_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   LEAD     = 4,
  parameter int   XW       = 11,
  parameter int   YW       = 10
) (
  input  logic          hdmi_clk,
  input  logic          reset,
  input  logic          i_enable,
  output logic [2:0]    o_hve,
  output logic          o_req,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]    IDLE_W = hve_idle(HS_POL, VS_POL);

  state_t        state, state_nx;
  logic [XW-1:0] h_cnt, h_nx;
  logic [YW-1:0] v_cnt, v_nx;
  logic          h_last, v_last, running;
  logic          de_raw, hs_raw, vs_raw;
  logic [2:0]    hve_q;

  assign h_last  = (h_cnt == H_LAST);
  assign v_last  = (v_cnt == V_LAST);
  assign running = (state != IDLE);

  assign de_raw = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_raw = (h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
  assign vs_raw = (v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_nx;
      h_cnt <= h_nx;
      v_cnt <= v_nx;
    end
  end

  always_comb begin
    state_nx = state;
    h_nx     = h_cnt;
    v_nx     = v_cnt;
    if (running) begin
      if (h_last) begin
        h_nx = '0;
        v_nx = v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_nx = h_cnt + 1'b1;
      end
    end
    case (state)
      IDLE: begin
        h_nx = '0;
        v_nx = '0;
        if (i_enable) state_nx = RUN;
      end
      RUN:   if (!i_enable) state_nx = DRAIN;
      // Stopping only at the last pixel of the frame keeps frames whole on the link.
      DRAIN: begin
        if (i_enable)                state_nx = RUN;
        else if (h_last && v_last)   state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      o_req         <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
      o_running     <= 1'b0;
      hve_q         <= IDLE_W;
    end else begin
      o_req         <= running && de_raw;
      o_x           <= (running && de_raw) ? h_cnt : '0;
      o_y           <= (running && de_raw) ? v_cnt : '0;
      o_line_start  <= running && (h_cnt == '0);
      o_frame_start <= running && (h_cnt == '0) && (v_cnt == '0);
      o_running     <= running;
      hve_q         <= running ? {de_raw, vs_raw, hs_raw} : IDLE_W;
    end
  end

  // hve_q sits alongside o_req, so LEAD more stages give exactly LEAD cycles of lead.
  video_delay_line #(
    .WIDTH (3),
    .DEPTH (LEAD),
    .INIT  (IDLE_W)
  ) u_hve_dly (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .d        (hve_q),
    .q        (o_hve)
  );

endmodule

// File: doc/video_timing.md
# video_timing

Video timing controller that sequences the HDMI output path. It generates the `{display_enable, vsync, hsync}` triple consumed by the `hdmi` block's `hve` input. It also issues per-pixel fetch requests with coordinates a fixed number of cycles ahead, so upstream pixel sources (framebuffer, sprite/rect renderer) can cover their pipeline latency and present `rgb` aligned with `display_enable`. Start and stop happen only on frame boundaries, so the TMDS encoders never see a torn frame.

## Interface

Parameters:
- `H_ACTIVE`, 1280: visible pixels per line
- `H_FP`, 110: horizontal front porch, cycles
- `H_SYNC`, 40: hsync width, cycles
- `H_BP`, 220: horizontal back porch, cycles
- `V_ACTIVE`, 720: visible lines
- `V_FP`, 5: vertical front porch, lines
- `V_SYNC`, 5: vsync width, lines
- `V_BP`, 20: vertical back porch, lines
- `HS_POL`, 1: hsync active level
- `VS_POL`, 1: vsync active level
- `LEAD`, 4: cycles from `o_req` to the matching `o_hve[2]`; legal range 1..H_FP+H_SYNC+H_BP
- `XW`, 11: width of `o_x`; 2^XW ≥ H_TOTAL
- `YW`, 10: width of `o_y`; 2^YW ≥ V_TOTAL

Ports:
- `hdmi_clk` in 1: pixel clock; the only clock
- `reset` in 1: asynchronous, active-high
- `i_enable` in 1: run request, level-sensitive
- `o_hve` out 3: `{display_enable, vsync, hsync}`; connects to `hdmi.hve`
- `o_req` out 1: pixel fetch request; the coordinates are valid
- `o_x` out XW: requested pixel column
- `o_y` out YW: requested pixel row
- `o_line_start` out 1: one-cycle pulse, h counter = 0 while running
- `o_frame_start` out 1: one-cycle pulse, h = v = 0 while running
- `o_running` out 1: high in RUN and DRAIN

## Operation

- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Horizontal order from h=0: active, front porch, sync, back porch. Vertical order is the same.
- Counters `h_cnt` (XW bits) and `v_cnt` (YW bits):
  - h wraps at H_TOTAL-1 to 0.
  - v increments on h wrap and wraps at V_TOTAL-1 to 0.
- Raw signals, computed from the counters:
  - de = h<H_ACTIVE && v<V_ACTIVE
  - hs = HS_POL when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL
  - vs = VS_POL over the vertical sync lines, else ~VS_POL; vs is line-granular and changes at h=0
- Request outputs are registered from the raw values: `o_req`=de, `o_x`=h, `o_y`=v.
- `o_hve` is the raw triple delayed through a LEAD-stage shift register.
- When not running, the idle word `{0, ~VS_POL, ~HS_POL}` is shifted in instead of the raw triple.
- `o_x`/`o_y` hold 0 whenever `o_req`=0.
- State machine (IDLE, RUN, DRAIN):
  - IDLE: counters held at 0. On `i_enable`=1 go to RUN. The first RUN cycle has h=v=0 and `o_frame_start`=1.
  - RUN: counters advance every cycle. On `i_enable`=0 go to DRAIN.
  - DRAIN: counters keep advancing. At h=H_TOTAL-1, v=V_TOTAL-1 go to IDLE and counters return to 0. If `i_enable` returns to 1 before that, go back to RUN with no counter disturbance.
- `i_enable` toggling within a single frame never shortens or restarts the frame.

## Timing

- Reset (asynchronous assert, any state):
  - state=IDLE, counters=0, shift register filled with the idle word
  - `o_req`=0, `o_x`=0, `o_y`=0, `o_line_start`=0, `o_frame_start`=0, `o_running`=0
  - `o_hve`=`{0, ~VS_POL, ~HS_POL}`
- Reset release follows `reset` synchronously at the next edge.
- Reset mid-frame truncates the frame immediately; that is accepted behaviour.
- Latency:
  - `i_enable` sampled high in IDLE: first `o_req` one cycle later.
  - `o_hve[2]` for a given pixel is asserted exactly LEAD cycles after its `o_req`.
  - `o_hve[1:0]` keep the same LEAD offset relative to the counters.
- `o_line_start`/`o_frame_start` are registered alongside `o_req`. They are not delayed by LEAD.
- Stop: after the DRAIN→IDLE transition, `o_hve` emits the idle word from LEAD cycles later onward.
- `o_running` is registered and goes high one cycle after the IDLE→RUN transition.

## Structure

- Package `video_timing_pkg`:
  - `state_t` enum {IDLE, RUN, DRAIN}
  - localparam sets for the 1280x720@60 and 640x480@60 modes
  - a `hve_idle(hs_pol, vs_pol)` function
- One sub-module, `video_delay_line`:
  - parameterised WIDTH/DEPTH shift register
  - async reset to an INIT value
  - instantiated with WIDTH=3, DEPTH=LEAD

## Test plan

Small bench parameters: H 4/1/2/1 (H_TOTAL 8), V 3/1/1/1 (V_TOTAL 6), LEAD=2, POL=1.

- `reset` held, then released with `i_enable`=0 for 20 cycles -> `o_hve`=3'b000, `o_req`=0, `o_running`=0 throughout.
- `i_enable`=1 -> `o_frame_start` and `o_req` high on the next cycle with x=0,y=0.
  - x steps 0..3 with `o_req`=1, then `o_req`=0 for 4 cycles.
  - `o_hve[2]` is high for 4 cycles starting 2 cycles after the first `o_req`.
- Run 2 full frames -> per frame: 48 cycles, 12 `o_req` cycles, 6 `o_line_start` pulses.
  - hsync high for 2 cycles per line, at h=5..6 delayed by 2.
  - vsync high for exactly 8 cycles (line v=4), delayed by 2.
- Deassert `i_enable` at v=1,h=2 -> the frame completes to v=5,h=7, then IDLE; `o_hve`=000 from 2 cycles later; no extra `o_req`.
- Deassert at v=0, reassert at v=3 -> no gap; next `o_frame_start` exactly 48 cycles after the previous one.
- Assert `reset` mid-line at x=2 -> same cycle, `o_hve`=000 and `o_req`=0. After release with `i_enable`=1, a new frame starts at x=0,y=0.
